// File: rtl/ysyx_23060184_axi_arbiter.sv
// Two-master AXI4-Lite arbiter: IFU (read-only) and MEMU (read/write) share one
// downstream bus, one transaction at a time, round-robin on contention.
module ysyx_23060184_axi_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned RESP_WIDTH  = 2,
  parameter int unsigned NUM_MASTERS = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  // IFU read
  input  logic [ADDR_WIDTH-1:0]   m0_araddr,
  input  logic                    m0_arvalid,
  output logic                    m0_arready,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
  output logic [RESP_WIDTH-1:0]   m0_rresp,
  output logic                    m0_rvalid,
  input  logic                    m0_rready,
  // MEMU read
  input  logic [ADDR_WIDTH-1:0]   m1_araddr,
  input  logic                    m1_arvalid,
  output logic                    m1_arready,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  output logic [RESP_WIDTH-1:0]   m1_rresp,
  output logic                    m1_rvalid,
  input  logic                    m1_rready,
  // MEMU write
  input  logic [ADDR_WIDTH-1:0]   m1_awaddr,
  input  logic                    m1_awvalid,
  output logic                    m1_awready,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
  input  logic                    m1_wvalid,
  output logic                    m1_wready,
  output logic [RESP_WIDTH-1:0]   m1_bresp,
  output logic                    m1_bvalid,
  input  logic                    m1_bready,
  // downstream read
  output logic [ADDR_WIDTH-1:0]   s_araddr,
  output logic                    s_arvalid,
  input  logic                    s_arready,
  input  logic [DATA_WIDTH-1:0]   s_rdata,
  input  logic [RESP_WIDTH-1:0]   s_rresp,
  input  logic                    s_rvalid,
  output logic                    s_rready,
  // downstream write
  output logic [ADDR_WIDTH-1:0]   s_awaddr,
  output logic                    s_awvalid,
  input  logic                    s_awready,
  output logic [DATA_WIDTH-1:0]   s_wdata,
  output logic [DATA_WIDTH/8-1:0] s_wstrb,
  output logic                    s_wvalid,
  input  logic                    s_wready,
  input  logic [RESP_WIDTH-1:0]   s_bresp,
  input  logic                    s_bvalid,
  output logic                    s_bready,
  output logic [NUM_MASTERS-1:0]  grant
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD0  = 2'd1,
    ST_RD1  = 2'd2,
    ST_WR1  = 2'd3
  } state_t;

  state_t                 state, next_state;
  logic                   last;
  logic                   last_d;
  logic [NUM_MASTERS-1:0] grant_d;
  logic                   req0, req1r, req1w, memu_wins;

  assign req0      = m0_arvalid;
  assign req1r     = m1_arvalid;
  assign req1w     = m1_awvalid | m1_wvalid;
  // MEMU takes the bus unless the IFU also asks and MEMU was served last
  assign memu_wins = !req0 || !last;

  // State, owner decode and round-robin history
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      grant <= '0;
      last  <= 1'b0;
    end else begin
      state <= next_state;
      grant <= grant_d;
      last  <= last_d;
    end
  end

  // Next-state selection and combinational channel forwarding
  always_comb begin
    next_state = state;
    last_d     = last;
    grant_d    = '0;
    m0_arready = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = '0;
    m0_rvalid  = 1'b0;
    m1_arready = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = '0;
    m1_rvalid  = 1'b0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bresp   = '0;
    m1_bvalid  = 1'b0;
    s_araddr   = '0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    s_awaddr   = '0;
    s_awvalid  = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (req1w && memu_wins) begin
          next_state = ST_WR1;
          last_d     = 1'b1;
        end else if (req1r && memu_wins) begin
          next_state = ST_RD1;
          last_d     = 1'b1;
        end else if (req0) begin
          next_state = ST_RD0;
          last_d     = 1'b0;
        end
      end
      ST_RD0: begin
        s_araddr   = m0_araddr;
        s_arvalid  = m0_arvalid;
        m0_arready = s_arready;
        m0_rdata   = s_rdata;
        m0_rresp   = s_rresp;
        m0_rvalid  = s_rvalid;
        s_rready   = m0_rready;
        if (s_rvalid && m0_rready) next_state = ST_IDLE;
      end
      ST_RD1: begin
        s_araddr   = m1_araddr;
        s_arvalid  = m1_arvalid;
        m1_arready = s_arready;
        m1_rdata   = s_rdata;
        m1_rresp   = s_rresp;
        m1_rvalid  = s_rvalid;
        s_rready   = m1_rready;
        if (s_rvalid && m1_rready) next_state = ST_IDLE;
      end
      ST_WR1: begin
        s_awaddr   = m1_awaddr;
        s_awvalid  = m1_awvalid;
        m1_awready = s_awready;
        s_wdata    = m1_wdata;
        s_wstrb    = m1_wstrb;
        s_wvalid   = m1_wvalid;
        m1_wready  = s_wready;
        m1_bresp   = s_bresp;
        m1_bvalid  = s_bvalid;
        s_bready   = m1_bready;
        if (s_bvalid && m1_bready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase

    case (next_state)
      ST_RD0:  grant_d = NUM_MASTERS'(1);
      ST_RD1,
      ST_WR1:  grant_d = NUM_MASTERS'(2);
      default: grant_d = '0;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060184_axi_arbiter.sv
// Directed self-checking bench for the two-master AXI4-Lite arbiter.
module tb_ysyx_23060184_axi_arbiter;

  logic        clk, rstn;
  logic [31:0] m0_araddr;  logic m0_arvalid, m0_arready;
  logic [31:0] m0_rdata;   logic [1:0] m0_rresp; logic m0_rvalid, m0_rready;
  logic [31:0] m1_araddr;  logic m1_arvalid, m1_arready;
  logic [31:0] m1_rdata;   logic [1:0] m1_rresp; logic m1_rvalid, m1_rready;
  logic [31:0] m1_awaddr;  logic m1_awvalid, m1_awready;
  logic [31:0] m1_wdata;   logic [3:0] m1_wstrb; logic m1_wvalid, m1_wready;
  logic [1:0]  m1_bresp;   logic m1_bvalid, m1_bready;
  logic [31:0] s_araddr;   logic s_arvalid, s_arready;
  logic [31:0] s_rdata;    logic [1:0] s_rresp; logic s_rvalid, s_rready;
  logic [31:0] s_awaddr;   logic s_awvalid, s_awready;
  logic [31:0] s_wdata;    logic [3:0] s_wstrb; logic s_wvalid, s_wready;
  logic [1:0]  s_bresp;    logic s_bvalid, s_bready;
  logic [1:0]  grant;

  int errors = 0;
  int checks = 0;

  ysyx_23060184_axi_arbiter dut (
    .clk(clk), .rstn(rstn),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_araddr = '0; m0_arvalid = 0; m0_rready = 0;
    m1_araddr = '0; m1_arvalid = 0; m1_rready = 0;
    m1_awaddr = '0; m1_awvalid = 0; m1_wdata = '0; m1_wstrb = '0; m1_wvalid = 0; m1_bready = 0;
    s_arready = 0; s_rdata = '0; s_rresp = '0; s_rvalid = 0;
    s_awready = 0; s_wready = 0; s_bresp = '0; s_bvalid = 0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    rstn = 1'b0;
    m0_arvalid = 1; m0_araddr = 32'h8000_0000;
    step(); step();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b want 00", grant); end
    checks++; if (s_arvalid !== 1'b0) begin errors++; $display("FAIL rst_s_arvalid: got %b want 0", s_arvalid); end
    rstn = 1'b1;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_release_grant: got %b want 00", grant); end
    step();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rst_after_grant: got %b want 01", grant); end
    checks++; if (s_arvalid !== 1'b1) begin errors++; $display("FAIL rst_after_arvalid: got %b want 1", s_arvalid); end
  endtask

  task automatic test_single_read();
    apply_reset();
    m0_arvalid = 1; m0_araddr = 32'h8000_0000; m0_rready = 1; m1_rready = 1;
    step();
    checks++; if (s_araddr !== 32'h8000_0000) begin errors++; $display("FAIL rd_s_araddr: got %h want 80000000", s_araddr); end
    s_arready = 1; #1;
    checks++; if (m0_arready !== 1'b1) begin errors++; $display("FAIL rd_m0_arready: got %b want 1", m0_arready); end
    step();
    m0_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b00; #1;
    checks++; if (m0_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_m0_rdata: got %h want deadbeef", m0_rdata); end
    checks++; if (m0_rvalid !== 1'b1) begin errors++; $display("FAIL rd_m0_rvalid: got %b want 1", m0_rvalid); end
    checks++; if (m0_rresp !== 2'b00) begin errors++; $display("FAIL rd_m0_rresp: got %b want 00", m0_rresp); end
    checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("FAIL rd_m1_rvalid: got %b want 0", m1_rvalid); end
    checks++; if (s_rready !== 1'b1) begin errors++; $display("FAIL rd_s_rready: got %b want 1", s_rready); end
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rd_grant_hold: got %b want 01", grant); end
    step();
    s_rvalid = 0; #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rd_grant_drop: got %b want 00", grant); end
  endtask

  task automatic test_tie();
    apply_reset();
    m0_arvalid = 1; m0_araddr = 32'h8000_0010;
    m1_arvalid = 1; m1_araddr = 32'h1000_0020;
    m0_rready = 1; m1_rready = 1;
    step();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL tie1_grant: got %b want 10", grant); end
    checks++; if (s_araddr !== 32'h1000_0020) begin errors++; $display("FAIL tie1_s_araddr: got %h want 10000020", s_araddr); end
    s_arready = 1; #1;
    checks++; if (m1_arready !== 1'b1) begin errors++; $display("FAIL tie1_m1_arready: got %b want 1", m1_arready); end
    checks++; if (m0_arready !== 1'b0) begin errors++; $display("FAIL tie1_m0_arready: got %b want 0", m0_arready); end
    step();
    m1_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rdata = 32'h1111_2222; #1;
    checks++; if (m1_rdata !== 32'h1111_2222) begin errors++; $display("FAIL tie1_m1_rdata: got %h want 11112222", m1_rdata); end
    checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL tie1_m0_rvalid: got %b want 0", m0_rvalid); end
    step();
    s_rvalid = 0; #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL tie1_bubble: got %b want 00", grant); end
    step();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL tie2_grant: got %b want 01", grant); end
    checks++; if (s_araddr !== 32'h8000_0010) begin errors++; $display("FAIL tie2_s_araddr: got %h want 80000010", s_araddr); end
    s_arready = 1;
    step();
    m0_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rdata = 32'h3333_4444; #1;
    checks++; if (m0_rdata !== 32'h3333_4444) begin errors++; $display("FAIL tie2_m0_rdata: got %h want 33334444", m0_rdata); end
    step();
    // new tie raised in the bubble after the IFU was served
    s_rvalid = 0; m0_arvalid = 1; m1_arvalid = 1; #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL tie3_bubble: got %b want 00", grant); end
    step();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL tie3_grant: got %b want 10", grant); end
  endtask

  task automatic test_write();
    apply_reset();
    m1_awvalid = 1; m1_awaddr = 32'h1000_03F8;
    m1_wvalid = 1; m1_wdata = 32'h41; m1_wstrb = 4'h1; m1_bready = 1;
    step();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL wr_grant: got %b want 10", grant); end
    checks++; if (s_awaddr !== 32'h1000_03F8) begin errors++; $display("FAIL wr_s_awaddr: got %h want 100003f8", s_awaddr); end
    checks++; if (s_wdata !== 32'h41 || s_wstrb !== 4'h1) begin errors++; $display("FAIL wr_s_wdata: got %h/%h want 41/1", s_wdata, s_wstrb); end
    s_wready = 1; #1;
    checks++; if (m1_wready !== 1'b1 || m1_awready !== 1'b0) begin errors++; $display("FAIL wr_w_first: got wready=%b awready=%b want 1/0", m1_wready, m1_awready); end
    step();
    m1_wvalid = 0; s_wready = 0; s_awready = 1; #1;
    checks++; if (m1_awready !== 1'b1 || s_wvalid !== 1'b0) begin errors++; $display("FAIL wr_aw_second: got awready=%b wvalid=%b want 1/0", m1_awready, s_wvalid); end
    step();
    m1_awvalid = 0; s_awready = 0; s_bvalid = 1; s_bresp = 2'b10; #1;
    checks++; if (m1_bresp !== 2'b10 || m1_bvalid !== 1'b1) begin errors++; $display("FAIL wr_bresp: got %b/%b want 10/1", m1_bresp, m1_bvalid); end
    checks++; if (s_bready !== 1'b1 || grant !== 2'b10) begin errors++; $display("FAIL wr_b_hold: got bready=%b grant=%b want 1/10", s_bready, grant); end
    step();
    s_bvalid = 0; #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL wr_grant_drop: got %b want 00", grant); end
  endtask

  task automatic test_write_over_read();
    apply_reset();
    m1_awvalid = 1; m1_wvalid = 1; m1_awaddr = 32'h1000_0100; m1_bready = 1;
    m1_arvalid = 1; m1_araddr = 32'h1000_0200; m1_rready = 1;
    step();
    checks++; if (grant !== 2'b10 || s_awvalid !== 1'b1 || s_arvalid !== 1'b0) begin errors++; $display("FAIL wor_write_first: got grant=%b aw=%b ar=%b want 10/1/0", grant, s_awvalid, s_arvalid); end
    s_awready = 1; s_wready = 1;
    step();
    m1_awvalid = 0; m1_wvalid = 0; s_awready = 0; s_wready = 0; s_bvalid = 1; s_bresp = 2'b00;
    step();
    s_bvalid = 0; #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL wor_bubble: got %b want 00", grant); end
    step();
    checks++; if (grant !== 2'b10 || s_arvalid !== 1'b1 || s_awvalid !== 1'b0) begin errors++; $display("FAIL wor_read_next: got grant=%b ar=%b aw=%b want 10/1/0", grant, s_arvalid, s_awvalid); end
    checks++; if (s_araddr !== 32'h1000_0200) begin errors++; $display("FAIL wor_s_araddr: got %h want 10000200", s_araddr); end
    s_arready = 1;
    step();
    m1_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rdata = 32'h5555_AAAA; s_rresp = 2'b11; #1;
    checks++; if (m1_rdata !== 32'h5555_AAAA || m1_rresp !== 2'b11) begin errors++; $display("FAIL wor_m1_rdata: got %h/%b want 5555aaaa/11", m1_rdata, m1_rresp); end
    step();
    s_rvalid = 0; #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL wor_grant_drop: got %b want 00", grant); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    m0_arvalid = 1; m0_araddr = 32'h8000_0040; m0_rready = 1;
    step();
    s_arready = 1;
    step();
    m0_arvalid = 0; s_arready = 0;
    rstn = 1'b0; s_rvalid = 1; s_rdata = 32'hCAFE_F00D; #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL mid_grant: got %b want 00", grant); end
    checks++; if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h0) begin errors++; $display("FAIL mid_m0_r: got %b/%h want 0/0", m0_rvalid, m0_rdata); end
    checks++; if (s_rready !== 1'b0) begin errors++; $display("FAIL mid_s_rready: got %b want 0", s_rready); end
    step();
    rstn = 1'b1;
    step();
    checks++; if (grant !== 2'b00 || m0_rvalid !== 1'b0) begin errors++; $display("FAIL mid_late_r: got grant=%b rvalid=%b want 00/0", grant, m0_rvalid); end
    s_rvalid = 0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_write();
    test_write_over_read();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
